// File: rtl/ddr_req_responder.sv
// Stand-in DDR responder: 4-phase read/write req/ack from a foreign clock domain into a 16-bit RAM.
// Request sampled -> accepted 2 clk later -> ack after LAT more; one access in flight, other request waits.
module ddr_req_responder #(
  parameter int ADDR_W = 12,
  parameter int LAT    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [23:0] readAddress,
  output logic        readAcknowledge,
  output logic [15:0] readData,
  input  logic        write,
  input  logic [23:0] writeAddress,
  input  logic [15:0] writeData,
  output logic        writeAcknowledge,
  output logic        busy,
  output logic        rangeErr
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, RD_ACK, WR_ACK} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t            state_q, state_d;
  logic              rd_meta_q, rd_meta_d, rd_s_q, rd_s_d;
  logic              wr_meta_q, wr_meta_d, wr_s_q, wr_s_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              oor_q, oor_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
  logic              range_err_q, range_err_d;
  logic              last_wr_q, last_wr_d;
  logic              pick_rd, pick_wr, mem_we;

  logic [15:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_meta_q   <= 1'b0;
      rd_s_q      <= 1'b0;
      wr_meta_q   <= 1'b0;
      wr_s_q      <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      oor_q       <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      range_err_q <= 1'b0;
      last_wr_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      rd_meta_q   <= rd_meta_d;
      rd_s_q      <= rd_s_d;
      wr_meta_q   <= wr_meta_d;
      wr_s_q      <= wr_s_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      oor_q       <= oor_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rd_ack_q    <= rd_ack_d;
      wr_ack_q    <= wr_ack_d;
      range_err_q <= range_err_d;
      last_wr_q   <= last_wr_d;
    end
  end

  // RAM has no reset: contents survive rst, and mem_we is gated by state so a reset kills a pending write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  // On a tie the kind not served last goes first.
  assign pick_rd = rd_s_q && (!wr_s_q || last_wr_q);
  assign pick_wr = wr_s_q && (!rd_s_q || !last_wr_q);

  always_comb begin
    state_d     = state_q;
    rd_meta_d   = read;
    rd_s_d      = rd_meta_q;
    wr_meta_d   = write;
    wr_s_d      = wr_meta_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    oor_d       = oor_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rd_ack_d    = rd_ack_q;
    wr_ack_d    = wr_ack_q;
    range_err_d = range_err_q;
    last_wr_d   = last_wr_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_rd) begin
          state_d     = RD_WAIT;
          cnt_d       = CNT_LOAD;
          addr_d      = readAddress[ADDR_W-1:0];
          oor_d       = |readAddress[23:ADDR_W];
          range_err_d = range_err_q | (|readAddress[23:ADDR_W]);
        end else if (pick_wr) begin
          state_d     = WR_WAIT;
          cnt_d       = CNT_LOAD;
          addr_d      = writeAddress[ADDR_W-1:0];
          oor_d       = |writeAddress[23:ADDR_W];
          wdata_d     = writeData;
          range_err_d = range_err_q | (|writeAddress[23:ADDR_W]);
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d   = oor_q ? 16'h0000 : mem[addr_q];
          rd_ack_d  = 1'b1;
          last_wr_d = 1'b0;
          state_d   = RD_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          mem_we    = !oor_q;
          wr_ack_d  = 1'b1;
          last_wr_d = 1'b1;
          state_d   = WR_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_ACK: begin
        if (!rd_s_q) begin
          rd_ack_d = 1'b0;
          state_d  = IDLE;
        end
      end
      WR_ACK: begin
        if (!wr_s_q) begin
          wr_ack_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign readAcknowledge  = rd_ack_q;
  assign writeAcknowledge = wr_ack_q;
  assign readData         = rdata_q;
  assign rangeErr         = range_err_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_ddr_req_responder.sv
// Directed bench for ddr_req_responder: latency, 4-phase order, round-robin, range errors,
// async reset mid-write, and a clk/3 requester streaming writes then reads.
module tb_ddr_req_responder;

  logic        clk = 1'b0;
  logic        rclk = 1'b0;
  logic        rst;
  logic        read, write;
  logic [23:0] readAddress, writeAddress;
  logic [15:0] writeData;
  logic        readAcknowledge, writeAcknowledge, busy, rangeErr;
  logic [15:0] readData;

  int n_cmp = 0;
  int n_err = 0;
  int rd_rise = 0;
  int wr_rise = 0;
  logic rd_prev = 1'b0;
  logic wr_prev = 1'b0;

  ddr_req_responder #(.ADDR_W(12), .LAT(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .read             (read),
    .readAddress      (readAddress),
    .readAcknowledge  (readAcknowledge),
    .readData         (readData),
    .write            (write),
    .writeAddress     (writeAddress),
    .writeData        (writeData),
    .writeAcknowledge (writeAcknowledge),
    .busy             (busy),
    .rangeErr         (rangeErr)
  );

  always #5 clk = ~clk;
  initial begin
    #2;
    forever #15 rclk = ~rclk;
  end

  always @(negedge clk) begin
    if (readAcknowledge && !rd_prev) rd_rise++;
    if (writeAcknowledge && !wr_prev) wr_rise++;
    rd_prev <= readAcknowledge;
    wr_prev <= writeAcknowledge;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input bit slow);
    if (slow) @(negedge rclk);
    else @(negedge clk);
  endtask

  task automatic wait_ack(input bit rd, input logic lvl, input bit slow, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(slow);
      if ((rd ? readAcknowledge : writeAcknowledge) == lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wr_op(input logic [23:0] a, input logic [15:0] d, input bit slow);
    bit ok;
    tick(slow);
    write = 1'b1; writeAddress = a; writeData = d;
    wait_ack(1'b0, 1'b1, slow, ok);
    chk("wr ack rise", 32'(ok), 1);
    write = 1'b0;
    wait_ack(1'b0, 1'b0, slow, ok);
    chk("wr ack fall", 32'(ok), 1);
  endtask

  task automatic rd_op(input logic [23:0] a, input bit slow, output logic [15:0] d);
    bit ok;
    tick(slow);
    read = 1'b1; readAddress = a;
    wait_ack(1'b1, 1'b1, slow, ok);
    chk("rd ack rise", 32'(ok), 1);
    d = readData;
    read = 1'b0;
    wait_ack(1'b1, 1'b0, slow, ok);
    chk("rd ack fall", 32'(ok), 1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 40503 + 4951);
  endfunction

  initial begin
    logic [15:0] d;
    bit ok;
    int base_r, base_w;
    rst = 1'b1; read = 1'b0; write = 1'b0;
    readAddress = '0; writeAddress = '0; writeData = '0;
    repeat (3) @(negedge clk);
    chk("rst rd ack", 32'(readAcknowledge), 0);
    chk("rst wr ack", 32'(writeAcknowledge), 0);
    chk("rst rdata", 32'(readData), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst range", 32'(rangeErr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // exact read latency: sampled at edge 0, ack after edge 5, drop two edges after read seen low
    wr_op(24'd5, 16'hBEEF, 1'b0);
    @(negedge clk);
    read = 1'b1; readAddress = 24'd5;
    repeat (5) @(negedge clk);
    chk("lat ack low e4", 32'(readAcknowledge), 0);
    chk("lat busy e4", 32'(busy), 1);
    @(negedge clk);
    chk("lat ack high e5", 32'(readAcknowledge), 1);
    chk("lat rdata", 32'(readData), 32'hBEEF);
    read = 1'b0;
    repeat (2) @(negedge clk);
    chk("ack held e7", 32'(readAcknowledge), 1);
    @(negedge clk);
    chk("ack drop e8", 32'(readAcknowledge), 0);
    chk("idle e8", 32'(busy), 0);

    // write then read back; a later write leaves readData alone
    wr_op(24'd10, 16'hA5A5, 1'b0);
    rd_op(24'd10, 1'b0, d);
    chk("rdback 10", 32'(d), 32'hA5A5);
    wr_op(24'd11, 16'h0F0F, 1'b0);
    chk("rdata kept", 32'(readData), 32'hA5A5);

    // tie from reset: read first
    reset_pulse();
    @(negedge clk);
    read = 1'b1; readAddress = 24'd10;
    write = 1'b1; writeAddress = 24'd20; writeData = 16'h1234;
    wait_ack(1'b1, 1'b1, 1'b0, ok);
    chk("tie1 rd ack", 32'(ok), 1);
    chk("tie1 wr waits", 32'(writeAcknowledge), 0);
    chk("tie1 rdata", 32'(readData), 32'hA5A5);
    read = 1'b0;
    wait_ack(1'b0, 1'b1, 1'b0, ok);
    chk("tie1 wr ack", 32'(ok), 1);
    chk("tie1 rd dropped", 32'(readAcknowledge), 0);
    write = 1'b0;
    wait_ack(1'b0, 1'b0, 1'b0, ok);
    chk("tie1 wr fall", 32'(ok), 1);
    // a solo read makes read the last served kind, so the next tie goes to write
    rd_op(24'd20, 1'b0, d);
    chk("rdback 20", 32'(d), 32'h1234);
    @(negedge clk);
    read = 1'b1; readAddress = 24'd10;
    write = 1'b1; writeAddress = 24'd21; writeData = 16'h5678;
    wait_ack(1'b0, 1'b1, 1'b0, ok);
    chk("tie2 wr ack", 32'(ok), 1);
    chk("tie2 rd waits", 32'(readAcknowledge), 0);
    write = 1'b0;
    wait_ack(1'b1, 1'b1, 1'b0, ok);
    chk("tie2 rd ack", 32'(ok), 1);
    chk("tie2 rdata", 32'(readData), 32'hA5A5);
    read = 1'b0;
    wait_ack(1'b1, 1'b0, 1'b0, ok);
    chk("tie2 rd fall", 32'(ok), 1);
    rd_op(24'd21, 1'b0, d);
    chk("rdback 21", 32'(d), 32'h5678);

    // out-of-range accesses
    chk("range clear", 32'(rangeErr), 0);
    wr_op(24'd0, 16'h1111, 1'b0);
    rd_op(24'h001000, 1'b0, d);
    chk("oor rdata", 32'(d), 0);
    chk("oor range set", 32'(rangeErr), 1);
    wr_op(24'h001000, 16'hDEAD, 1'b0);
    chk("oor range sticky", 32'(rangeErr), 1);
    rd_op(24'd0, 1'b0, d);
    chk("ram0 intact", 32'(d), 32'h1111);
    chk("range still set", 32'(rangeErr), 1);

    // async reset in the middle of a write
    wr_op(24'd30, 16'h3333, 1'b0);
    @(negedge clk);
    write = 1'b1; writeAddress = 24'd30; writeData = 16'h4444;
    repeat (4) @(negedge clk);
    chk("mid wr busy", 32'(busy), 1);
    chk("mid wr no ack", 32'(writeAcknowledge), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst busy", 32'(busy), 0);
    chk("arst wr ack", 32'(writeAcknowledge), 0);
    chk("arst rd ack", 32'(readAcknowledge), 0);
    chk("arst rdata", 32'(readData), 0);
    chk("arst range", 32'(rangeErr), 0);
    write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rd_op(24'd30, 1'b0, d);
    chk("arst ram kept", 32'(d), 32'h3333);

    // clk/3 requester: 480 writes then 480 reads
    base_r = rd_rise;
    base_w = wr_rise;
    for (int i = 0; i < 480; i++) wr_op(24'(100 + 7 * i), pat(i), 1'b1);
    for (int i = 0; i < 480; i++) begin
      rd_op(24'(100 + 7 * i), 1'b1, d);
      chk("stream rdata", 32'(d), 32'(pat(i)));
    end
    repeat (4) @(negedge clk);
    chk("stream wr acks", 32'(wr_rise - base_w), 480);
    chk("stream rd acks", 32'(rd_rise - base_r), 480);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
